csync_decoder: RTL and testbench

Receive-side counterpart of the chipset beam-timing generator: decodes the active-low composite sync (CSYNC) stream back into line/frame strobes, beam position counters, field parity and PAL/NTSC detection. It sits on the video-output side of the simulation bench. It checks the generated timing and provides beam coordinates to display and capture logic that only sees CSYNC. All timing is measured in CCK ticks (3.546895 MHz PAL / 3.579545 MHz NTSC), supplied as a one-cycle enable.

---
 rtl/csync_pkg.sv | 31 +++
 rtl/csync_pulse_meter.sv | 51 +++++
 rtl/csync_decoder.sv | 137 +++++++++++++
 tb/tb_csync_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csync_pkg.sv
// Shared types and default thresholds for the composite-sync decoder.
package csync_pkg;

  localparam int unsigned HPOS_W  = 9;
  localparam int unsigned VPOS_W  = 10;
  localparam int unsigned WIDTH_W = 8;

  localparam int unsigned EQ_MAX_DEF    = 12;
  localparam int unsigned HS_MAX_DEF    = 40;
  localparam int unsigned LINE_MIN_DEF  = 200;
  localparam int unsigned PAL_LINES_DEF = 288;

  typedef enum logic [1:0] {
    SEARCH,
    SYNCED,
    LOCKED
  } state_t;

  typedef enum logic [1:0] {
    P_EQ,
    P_HS,
    P_BROAD
  } pclass_t;

  // Magnitude of the difference between two line counts.
  function automatic logic [VPOS_W-1:0] abs_diff(input logic [VPOS_W-1:0] a,
                                                 input logic [VPOS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/csync_pulse_meter.sv
// Samples CSYNC on CCK ticks, detects edges and measures/classifies low pulses.
module csync_pulse_meter
  import csync_pkg::*;
#(
  parameter int unsigned EQ_MAX = EQ_MAX_DEF,
  parameter int unsigned HS_MAX = HS_MAX_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    ena,
  input  logic    csync_n,
  output logic    fall_c,
  output logic    rise_c,
  output pclass_t pclass_c
);

  localparam logic [WIDTH_W-1:0] EQ_LIM = WIDTH_W'(EQ_MAX);
  localparam logic [WIDTH_W-1:0] HS_LIM = WIDTH_W'(HS_MAX);
  localparam logic [WIDTH_W-1:0] W_MAX  = '1;

  logic               csync_q;
  logic [WIDTH_W-1:0] w;

  // Edge strobes are only meaningful on a tick; classification uses the width so far.
  always_comb begin
    fall_c   = ena && !csync_n && csync_q;
    rise_c   = ena && csync_n && !csync_q;
    pclass_c = P_BROAD;
    if (w < EQ_LIM) begin
      pclass_c = P_EQ;
    end else if (w < HS_LIM) begin
      pclass_c = P_HS;
    end
  end

  // Delayed input sample and saturating low-width counter (cleared by a falling edge).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csync_q <= 1'b1;
      w       <= '0;
    end else if (ena) begin
      csync_q <= csync_n;
      if (fall_c) begin
        w <= '0;
      end else if (!csync_n && (w != W_MAX)) begin
        w <= w + WIDTH_W'(1);
      end
    end
  end

endmodule

// File: rtl/csync_decoder.sv
// Composite-sync decoder: beam position, line/frame strobes, field parity and lock tracking.
module csync_decoder
  import csync_pkg::*;
#(
  parameter int unsigned EQ_MAX    = EQ_MAX_DEF,
  parameter int unsigned HS_MAX    = HS_MAX_DEF,
  parameter int unsigned LINE_MIN  = LINE_MIN_DEF,
  parameter int unsigned PAL_LINES = PAL_LINES_DEF
) (
  input  logic              main_clk,
  input  logic              main_rst,
  input  logic              ena_cck,
  input  logic              csync_n,
  output logic [HPOS_W-1:0] hpos,
  output logic [VPOS_W-1:0] vpos,
  output logic              hs_stb,
  output logic              vs_stb,
  output logic              field_odd,
  output logic [VPOS_W-1:0] frame_lines,
  output logic              pal_det,
  output logic              locked
);

  localparam logic [HPOS_W-1:0] HPOS_MAX   = '1;
  localparam logic [VPOS_W-1:0] VPOS_MAX   = '1;
  localparam logic [HPOS_W-1:0] LINE_MIN_L = HPOS_W'(LINE_MIN);
  localparam logic [VPOS_W-1:0] PAL_L      = VPOS_W'(PAL_LINES);

  logic              fall_c;
  logic              rise_c;
  pclass_t           pclass_c;
  pclass_t           prev_class;
  logic [HPOS_W-1:0] pstart;
  state_t            state;
  state_t            state_nx;
  logic              line_start_c;
  logic              vs_ev_c;
  logic              timeout_c;
  logic              close_c;

  csync_pulse_meter #(
    .EQ_MAX (EQ_MAX),
    .HS_MAX (HS_MAX)
  ) u_meter (
    .clk      (main_clk),
    .rst_n    (main_rst),
    .ena      (ena_cck),
    .csync_n  (csync_n),
    .fall_c   (fall_c),
    .rise_c   (rise_c),
    .pclass_c (pclass_c)
  );

  // Event decode: accepted line start, leading broad pulse, and hpos running into saturation.
  always_comb begin
    line_start_c = fall_c && (hpos >= LINE_MIN_L);
    vs_ev_c      = rise_c && (pclass_c == P_BROAD) && (prev_class != P_BROAD);
    timeout_c    = ena_cck && !line_start_c && (hpos >= (HPOS_MAX - HPOS_W'(1)));
    close_c      = abs_diff(vpos, frame_lines) <= VPOS_W'(1);
  end

  // Lock state machine: next state.
  always_comb begin
    state_nx = state;
    if (vs_ev_c) begin
      case (state)
        SEARCH:  state_nx = SYNCED;
        SYNCED:  if (close_c) state_nx = LOCKED;
        LOCKED:  if (!close_c) state_nx = SYNCED;
        default: state_nx = SEARCH;
      endcase
    end
    if (timeout_c) begin
      state_nx = SEARCH;
    end
  end

  // Lock state machine: state register.
  always_ff @(posedge main_clk) begin
    if (!main_rst) begin
      state <= SEARCH;
    end else begin
      state <= state_nx;
    end
  end

  // Position counters, strobes, field parity and frame length capture.
  always_ff @(posedge main_clk) begin
    if (!main_rst) begin
      hpos        <= '0;
      vpos        <= '0;
      hs_stb      <= 1'b0;
      vs_stb      <= 1'b0;
      field_odd   <= 1'b0;
      frame_lines <= '0;
      pal_det     <= 1'b0;
      locked      <= 1'b0;
      pstart      <= '0;
      prev_class  <= P_EQ;
    end else begin
      hs_stb <= 1'b0;
      vs_stb <= 1'b0;
      locked <= (state_nx == LOCKED);
      if (ena_cck) begin
        if (line_start_c) begin
          hpos   <= '0;
          hs_stb <= 1'b1;
          if (vpos != VPOS_MAX) begin
            vpos <= vpos + VPOS_W'(1);
          end
        end else if (hpos != HPOS_MAX) begin
          hpos <= hpos + HPOS_W'(1);
        end
        if (fall_c) begin
          pstart <= line_start_c ? '0 : hpos;
        end
        if (rise_c) begin
          prev_class <= pclass_c;
        end
        if (vs_ev_c) begin
          vs_stb    <= 1'b1;
          vpos      <= '0;
          field_odd <= (pstart != '0);
          // The first frame after SEARCH was only partially counted.
          if (state != SEARCH) begin
            frame_lines <= vpos;
            pal_det     <= (vpos >= PAL_L);
          end
        end
        if (timeout_c) begin
          vpos <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_csync_decoder.sv
// Randomized CSYNC frames checked tick-by-tick against a line/frame-level model.
module tb_csync_decoder;

  localparam int LINE_MIN  = 200;
  localparam int HS_MAX    = 40;
  localparam int PAL_LINES = 20;
  localparam int L_PAL     = 22;
  localparam int L_NTSC    = 16;
  localparam int K_EQ      = 0;
  localparam int K_HS      = 1;
  localparam int K_BR      = 2;

  logic       main_clk = 1'b0;
  logic       main_rst = 1'b0;
  logic       ena_cck  = 1'b0;
  logic       csync_n  = 1'b1;
  logic [8:0] hpos;
  logic [9:0] vpos;
  logic       hs_stb;
  logic       vs_stb;
  logic       field_odd;
  logic [9:0] frame_lines;
  logic       pal_det;
  logic       locked;

  int ncmp = 0;
  int nfail = 0;
  int vs_seen = 0;

  // Model state: ticks since last line start, line starts since last vsync, etc.
  int m_since, m_lines, m_prev_c, m_low_run, m_pstart, m_prev_broad;
  int m_fl, m_pal, m_field, m_acq, m_lock, e_hs, e_vs;

  csync_decoder #(.PAL_LINES(PAL_LINES)) dut (
    .main_clk    (main_clk),
    .main_rst    (main_rst),
    .ena_cck     (ena_cck),
    .csync_n     (csync_n),
    .hpos        (hpos),
    .vpos        (vpos),
    .hs_stb      (hs_stb),
    .vs_stb      (vs_stb),
    .field_odd   (field_odd),
    .frame_lines (frame_lines),
    .pal_det     (pal_det),
    .locked      (locked)
  );

  always #5 main_clk = ~main_clk;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
    ncmp++;
    assert (obs === 32'(exp_v)) else begin
      nfail++;
      if (nfail <= 30) $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_since = 0; m_lines = 0; m_prev_c = 1; m_low_run = 0; m_pstart = 0;
    m_prev_broad = 0; m_fl = 0; m_pal = 0; m_field = 0; m_acq = 0; m_lock = 0;
    e_hs = 0; e_vs = 0;
  endtask

  // One CCK tick of the reference: a pulse of L low ticks has width L-1 when it ends.
  task automatic model_tick(input int c);
    int hp, fall, rise, ls, broad, vs, cur, diff;
    hp    = sat(m_since, 511);
    fall  = (c == 0 && m_prev_c == 1) ? 1 : 0;
    rise  = (c == 1 && m_prev_c == 0) ? 1 : 0;
    ls    = (fall != 0 && hp >= LINE_MIN) ? 1 : 0;
    broad = (rise != 0 && (m_low_run - 1) >= HS_MAX) ? 1 : 0;
    vs    = (broad != 0 && m_prev_broad == 0) ? 1 : 0;
    if (rise != 0) m_prev_broad = broad;
    if (fall != 0) begin
      m_pstart  = (ls != 0) ? 0 : hp;
      m_low_run = 1;
    end else if (c == 0) begin
      m_low_run++;
    end
    m_since = (ls != 0) ? 0 : m_since + 1;
    if (ls != 0) m_lines++;
    if (vs != 0) begin
      m_field = (m_pstart != 0) ? 1 : 0;
      if (m_acq == 0) begin
        m_acq = 1;
      end else begin
        cur  = sat(m_lines, 1023);
        diff = cur - m_fl;
        if (diff < 0) diff = -diff;
        m_lock = (diff <= 1) ? 1 : 0;
        m_fl   = cur;
        m_pal  = (cur >= PAL_LINES) ? 1 : 0;
      end
      m_lines = 0;
    end
    if (m_since >= 511) begin
      m_acq = 0; m_lock = 0; m_lines = 0;
    end
    e_hs = ls; e_vs = vs; m_prev_c = c;
  endtask

  task automatic check_all();
    chk("hpos",        32'(hpos),        sat(m_since, 511));
    chk("vpos",        32'(vpos),        sat(m_lines, 1023));
    chk("hs_stb",      32'(hs_stb),      e_hs);
    chk("vs_stb",      32'(vs_stb),      e_vs);
    chk("field_odd",   32'(field_odd),   m_field);
    chk("frame_lines", 32'(frame_lines), m_fl);
    chk("pal_det",     32'(pal_det),     m_pal);
    chk("locked",      32'(locked),      m_lock);
  endtask

  // One tick, sometimes preceded by an idle main_clk cycle in which everything must hold.
  task automatic step(input int c);
    if ($urandom_range(0, 7) == 0) begin
      ena_cck = 1'b0;
      @(posedge main_clk); #1;
      e_hs = 0; e_vs = 0;
      check_all();
    end
    ena_cck = 1'b1;
    csync_n = 1'(c);
    @(posedge main_clk); #1;
    model_tick(c);
    check_all();
    if (vs_stb === 1'b1) vs_seen++;
    ena_cck = 1'b0;
  endtask

  task automatic pulse(input int low, input int total);
    for (int i = 0; i < low; i++) step(0);
    for (int i = low; i < total; i++) step(1);
  endtask

  function automatic int rnd_w(input int kind);
    if (kind == K_EQ) return int'($urandom_range(3, 10));
    if (kind == K_HS) return int'($urandom_range(14, 30));
    return int'($urandom_range(60, 100));
  endfunction

  task automatic line2(input int ka, input int kb);
    int len;
    len = 227 + int'($urandom_range(0, 2));
    pulse(rnd_w(ka), 113);
    pulse(rnd_w(kb), len - 113);
  endtask

  task automatic normal();
    pulse(rnd_w(K_HS), 227 + int'($urandom_range(0, 2)));
  endtask

  // Frame of n lines; the first broad pulse starts on a line (even) or mid-line (odd).
  task automatic frame(input int n, input int odd);
    if (odd == 0) begin
      line2(K_EQ, K_EQ); line2(K_EQ, K_EQ); line2(K_BR, K_BR);
      line2(K_BR, K_BR); line2(K_BR, K_EQ); line2(K_EQ, K_EQ);
    end else begin
      line2(K_EQ, K_EQ); line2(K_EQ, K_EQ); line2(K_EQ, K_BR);
      line2(K_BR, K_BR); line2(K_BR, K_BR); line2(K_EQ, K_EQ);
    end
    repeat (n - 6) normal();
  endtask

  initial begin
    // Power-on reset, including a tick asserted while in reset.
    model_reset();
    repeat (2) @(posedge main_clk);
    #1 ena_cck = 1'b1;
    @(posedge main_clk);
    #1 ena_cck = 1'b0;
    main_rst = 1'b1;
    check_all();
    chk("rst_locked", 32'(locked), 0);

    // PAL-like progressive: lock after the third vsync.
    repeat (3) normal();
    repeat (3) frame(L_PAL, 0);
    chk("pal_locked", 32'(locked), 1);
    chk("pal_lines",  32'(frame_lines), L_PAL);
    chk("pal_det",    32'(pal_det), 1);
    chk("pal_field",  32'(field_odd), 0);

    // NTSC-like progressive: relock at the shorter length.
    repeat (3) frame(L_NTSC, 0);
    chk("ntsc_locked", 32'(locked), 1);
    chk("ntsc_lines",  32'(frame_lines), L_NTSC);
    chk("ntsc_det",    32'(pal_det), 0);

    // Interlace: alternating lengths differing by one, field parity toggles.
    frame(L_PAL + 1, 1);
    frame(L_PAL, 0);
    frame(L_PAL + 1, 1);
    frame(L_PAL, 0);
    chk("il_locked", 32'(locked), 1);
    chk("il_field",  32'(field_odd), 0);
    chk("il_lines",  32'(frame_lines), L_PAL + 1);

    // Loss of sync: csync held high, frame length is retained.
    repeat (600) step(1);
    chk("to_locked", 32'(locked), 0);
    chk("to_lines",  32'(frame_lines), L_PAL + 1);
    chk("to_pal",    32'(pal_det), 1);
    chk("to_vpos",   32'(vpos), 0);
    chk("to_hpos",   32'(hpos), 511);

    // Reset pulse mid-line.
    repeat (2) normal();
    repeat (20) step(0);
    repeat (50) step(1);
    main_rst = 1'b0;
    ena_cck  = 1'($urandom_range(0, 1));
    csync_n  = 1'b1;
    @(posedge main_clk); #1;
    main_rst = 1'b1;
    ena_cck  = 1'b0;
    model_reset();
    check_all();
    chk("mrst_hpos",  32'(hpos), 0);
    chk("mrst_lines", 32'(frame_lines), 0);

    // Broad threshold boundary: 40 low ticks is hsync, 41 is broad.
    vs_seen = 0;
    pulse(40, 228);
    pulse(40, 228);
    pulse(41, 228);
    normal();
    pulse(41, 228);
    normal();
    chk("vs_count", 32'(vs_seen), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
